prog_loader: RTL and testbench

Runtime program loader for the 4-bit microprocessor: accepts a nibble stream over a valid/ready handshake, packs nibbles into instruction words and writes them sequentially into the processor's program memory from address 0. It holds the CPU in reset for the whole load, then releases it. It is the write side of the instruction store, which the processor core reads from. It sits between a host-facing input (bench or UART front end) and the program RAM / CPU reset inputs inside `top`.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/nibble_packer.sv | 48 ++++
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the runtime program loader.
//   state_t        - loader FSM encoding (IDLE=0, LOAD=1, WRITE=2, RELEASE=3)
//   nibs_per_word  - number of input nibbles packed into one program word
//   cnt_width      - width of a counter that indexes 0..n-1 (never below 1 bit)
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic int nibs_per_word(input int instr_width, input int bit_width);
    return instr_width / bit_width;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// nibble_packer: MSB-first shift register that assembles program words from
// input nibbles.
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - discard any partial word and restart the nibble count
//   shift      - shift din into the low end of the word
//   din        - incoming nibble
//   word_next  - word including din as the newest nibble (valid when shift is high)
//   nib_cnt    - number of nibbles already held for the current word
module nibble_packer
  import prog_loader_pkg::*;
#(
  parameter int BIT_WIDTH   = 4,
  parameter int INSTR_WIDTH = 8,
  localparam int NIBS       = nibs_per_word(INSTR_WIDTH, BIT_WIDTH),
  localparam int CNT_W      = cnt_width(NIBS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [BIT_WIDTH-1:0]   din,
  output logic [INSTR_WIDTH-1:0] word_next,
  output logic [CNT_W-1:0]       nib_cnt
);

  logic [INSTR_WIDTH-1:0] word_q;
  logic                   last;

  // Older nibbles move up, so the first nibble of a word ends in the MSBs.
  assign word_next = (word_q << BIT_WIDTH) | INSTR_WIDTH'(din);
  assign last      = (nib_cnt == CNT_W'(NIBS - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      nib_cnt <= '0;
    end else if (clear) begin
      word_q  <= '0;
      nib_cnt <= '0;
    end else if (shift) begin
      word_q  <= word_next;
      nib_cnt <= last ? '0 : nib_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a program into the CPU's instruction memory from a nibble
// stream, holding the CPU in reset until the last word has been written.
//   clk, rst    - clock, asynchronous active-high reset
//   load_start  - request a load of load_len words (honoured only when idle)
//   load_len    - words to load, 1..2^ADDR_WIDTH; other values are ignored
//   in_data     - nibble input, handshaked by in_valid / in_ready
//   mem_we      - program memory write strobe, with mem_addr / mem_wdata
//   cpu_rst     - hold-reset to the CPU core while a load is in progress
//   busy        - loader is not idle
//   done        - one-cycle pulse when the final word has been written
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int BIT_WIDTH   = 4,
  parameter int INSTR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH:0]    load_len,
  input  logic [BIT_WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done
);

  localparam int NIBS  = nibs_per_word(INSTR_WIDTH, BIT_WIDTH);
  localparam int CNT_W = cnt_width(NIBS);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    len_q;
  logic [ADDR_WIDTH-1:0]  word_cnt_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [INSTR_WIDTH-1:0] mem_wdata_q;

  logic                   pk_clear;
  logic                   pk_shift;
  logic [INSTR_WIDTH-1:0] pk_word_next;
  logic [CNT_W-1:0]       nib_cnt;

  logic start_ok;
  logic last_nib;
  logic last_word;

  assign start_ok  = load_start && (load_len != '0) && (load_len <= MAX_LEN);
  assign last_nib  = (nib_cnt == CNT_W'(NIBS - 1));
  assign last_word = ({1'b0, word_cnt_q} == (len_q - ONE));

  nibble_packer #(
    .BIT_WIDTH   (BIT_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .shift     (pk_shift),
    .din       (in_data),
    .word_next (pk_word_next),
    .nib_cnt   (nib_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          pk_clear = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          pk_shift = 1'b1;
          if (last_nib) state_d = ST_WRITE;
        end
      end
      ST_WRITE:   state_d = last_word ? ST_RELEASE : ST_LOAD;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Address and data are captured with the final nibble of each word so they
  // are valid throughout WRITE and hold their values afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      word_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start_ok) begin
        len_q      <= load_len;
        word_cnt_q <= '0;
      end
      if (state_q == ST_WRITE && !last_word) begin
        word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
      if (state_q == ST_LOAD && in_valid && last_nib) begin
        mem_addr_q  <= word_cnt_q;
        mem_wdata_q <= pk_word_next;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    mem_we    = (state_q == ST_WRITE);
    cpu_rst   = (state_q != ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_RELEASE);
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized checks of prog_loader against a
// word-level reference model (expected words are built from the nibble list).
module tb_prog_loader;

  localparam int BW   = 4;
  localparam int IW   = 8;
  localparam int AW   = 4;
  localparam int NIBS = IW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;

  prog_loader #(
    .BIT_WIDTH   (BW),
    .INSTR_WIDTH (IW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  always @(posedge clk) cyc++;

  // Write / pulse monitor, sampled mid-cycle.
  logic [AW-1:0] wa_q[$];
  logic [IW-1:0] wd_q[$];
  int done_cnt  = 0;
  int done_cyc  = 0;
  int rst_mis   = 0;
  int busy_cyc  = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy !== cpu_rst) rst_mis++;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every task leaves time at 1 unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    rst_mis  = 0;
    busy_cyc = 0;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = (AW + 1)'(len);
    start_cyc  = cyc;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send_nib(input logic [BW-1:0] d, input int gap);
    bit ok;
    in_valid = 1'b0;
    if (gap > 0) tick(gap);
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        tick(1);
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        ok = 1'b0 | 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: pack nibbles MSB-first into words with plain arithmetic.
  function automatic logic [IW-1:0] pack_word(input logic [BW-1:0] nibs[$], input int w);
    int acc;
    acc = 0;
    for (int n = 0; n < NIBS; n++) acc = acc * (1 << BW) + int'(nibs[w * NIBS + n]);
    return IW'(acc);
  endfunction

  logic [BW-1:0] nibs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- Reset values and idle behaviour ----
    rst = 1'b1; load_start = 1'b0; load_len = '0; in_data = '0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick(2);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h7;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    tick(1);

    // ---- len=2, full rate, fixed nibbles ----
    clear_mon();
    nibs = '{4'hA, 4'h5, 4'h3, 4'hC};
    start_load(2);
    check("len2_cpu_rst_rise", 32'(cpu_rst), 32'd1);
    check("len2_in_ready_rise", 32'(in_ready), 32'd1);
    foreach (nibs[i]) send_nib(nibs[i], 0);
    wait_idle(20);
    check("len2_nwrites", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("len2_addr0", 32'(wa_q[0]), 32'd0);
      check("len2_data0", 32'(wd_q[0]), 32'hA5);
      check("len2_addr1", 32'(wa_q[1]), 32'd1);
      check("len2_data1", 32'(wd_q[1]), 32'h3C);
    end
    check("len2_done_cnt", 32'(done_cnt), 32'd1);
    check("len2_done_latency", 32'(done_cyc - start_cyc), 32'd7);
    check("len2_cpu_rst_tracks_busy", 32'(rst_mis), 32'd0);
    check("len2_cpu_rst_released", 32'(cpu_rst), 32'd0);
    check("len2_addr_hold", 32'(mem_addr), 32'd1);
    check("len2_data_hold", 32'(mem_wdata), 32'h3C);

    // ---- len=16, random nibbles with 0..3 cycle gaps ----
    clear_mon();
    nibs.delete();
    for (int i = 0; i < 16 * NIBS; i++) nibs.push_back(BW'($urandom_range(0, (1 << BW) - 1)));
    start_load(16);
    foreach (nibs[i]) send_nib(nibs[i], int'($urandom_range(0, 3)));
    wait_idle(20);
    check("len16_nwrites", 32'(wa_q.size()), 32'd16);
    for (int w = 0; w < 16 && w < wa_q.size(); w++) begin
      check($sformatf("len16_addr%0d", w), 32'(wa_q[w]), 32'(w));
      check($sformatf("len16_data%0d", w), 32'(wd_q[w]), 32'(pack_word(nibs, w)));
    end
    check("len16_done_cnt", 32'(done_cnt), 32'd1);
    check("len16_cpu_rst_tracks_busy", 32'(rst_mis), 32'd0);

    // ---- Out-of-range lengths are ignored ----
    clear_mon();
    start_load(0);
    tick(5);
    start_load(17);
    tick(5);
    check("badlen_busy_cycles", 32'(busy_cyc), 32'd0);
    check("badlen_nwrites", 32'(wa_q.size()), 32'd0);
    check("badlen_done_cnt", 32'(done_cnt), 32'd0);

    // ---- load_start during a load is ignored ----
    clear_mon();
    nibs.delete();
    for (int i = 0; i < 3 * NIBS; i++) nibs.push_back(BW'($urandom_range(0, (1 << BW) - 1)));
    start_load(3);
    send_nib(nibs[0], 0);
    load_start = 1'b1;
    load_len   = (AW + 1)'(2);
    tick(1);
    load_start = 1'b0;
    for (int i = 1; i < nibs.size(); i++) send_nib(nibs[i], 0);
    wait_idle(20);
    check("restart_nwrites", 32'(wa_q.size()), 32'd3);
    for (int w = 0; w < 3 && w < wa_q.size(); w++) begin
      check($sformatf("restart_addr%0d", w), 32'(wa_q[w]), 32'(w));
      check($sformatf("restart_data%0d", w), 32'(wd_q[w]), 32'(pack_word(nibs, w)));
    end
    check("restart_done_cnt", 32'(done_cnt), 32'd1);

    // ---- Reset in the middle of a load ----
    clear_mon();
    nibs = '{4'h1, 4'hE, 4'h6};
    start_load(4);
    foreach (nibs[i]) send_nib(nibs[i], 0);
    rst = 1'b1;
    #1;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("midrst_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) check("midrst_data0", 32'(wd_q[0]), 32'h1E);
    check("midrst_done_cnt", 32'(done_cnt), 32'd0);

    // ---- Fresh load after reset ----
    clear_mon();
    nibs = '{4'h9, 4'h2};
    start_load(1);
    foreach (nibs[i]) send_nib(nibs[i], 1);
    wait_idle(20);
    check("fresh_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("fresh_addr0", 32'(wa_q[0]), 32'd0);
      check("fresh_data0", 32'(wd_q[0]), 32'(pack_word(nibs, 0)));
    end
    check("fresh_done_cnt", 32'(done_cnt), 32'd1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
